vga_bounce_controller: RTL and testbench
========================================

# vga_bounce_controller

Self-contained VGA pixel source that generates its own parametrised sync timing and draws one solid box that bounces around the visible area. The box moves by a programmable step once per frame and reflects off the screen edges. Box and background colours are programmable. It drives the DE1-SoC VGA DAC pins directly and sits at the top of the video path as the next-generation replacement for the fixed-square controller.

## Interface

- H_VISIBLE, 640, active pixels per line
- H_FRONT, 16, horizontal front porch (clocks)
- H_SYNC, 96, horizontal sync width (clocks)
- H_BACK, 48, horizontal back porch (clocks)
- V_VISIBLE, 480, active lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BACK, 33, vertical back porch (lines)
- BOX_SIZE, 100, box edge length in pixels; must be less than V_VISIBLE
- BOX_X0, 100, box left edge after reset
- BOX_Y0, 100, box top edge after reset
- COLOR_W, 8, bits per colour channel
- vga_clk  in  1  pixel clock; the only clock
- reset_n  in  1  asynchronous, active-low reset
- enable  in  1  animation enable, sampled at each position update
- step  in  4  pixels moved per frame on each axis, sampled at update
- box_color  in  3*COLOR_W  {red, green, blue}, red in the MSBs
- bg_color  in  3*COLOR_W  background colour, same packing
- blank_n  out  1  high during active video
- HS  out  1  horizontal sync, active-low
- VS  out  1  vertical sync, active-low
- red / green / blue  out  COLOR_W each  pixel colour; 0 when blanked
- frame_start  out  1  one-cycle pulse on the output cycle for pixel (0,0)
- box_x / box_y  out  11 each  current box top-left position

## Operation

- Counters h_cnt (0..H_TOTAL-1) and v_cnt (0..V_TOTAL-1) are 11 bits wide. H_TOTAL is the sum of the four H_* parameters (800 by default); V_TOTAL is the sum of the four V_* parameters (525 by default).
- h_cnt wraps to 0 after H_TOTAL-1. At that wrap v_cnt increments, and v_cnt wraps to 0 after V_TOTAL-1.
- visible is true when h_cnt < H_VISIBLE and v_cnt < V_VISIBLE.
- HS is low while H_VISIBLE+H_FRONT <= h_cnt < H_VISIBLE+H_FRONT+H_SYNC.
- VS is low while V_VISIBLE+V_FRONT <= v_cnt < V_VISIBLE+V_FRONT+V_SYNC.
- Box hit: box_x <= h_cnt < box_x+BOX_SIZE and box_y <= v_cnt < box_y+BOX_SIZE. Both bounds are half-open.
- Colour selection: not visible gives 0; box hit gives box_color; otherwise bg_color.
- Position update happens on the single cycle where h_cnt==0 and v_cnt==V_VISIBLE, which is the first blanking line. Position therefore never changes mid-frame.
- Update does nothing when enable==0 or step==0; position and direction are held.
- X axis moving right: if box_x+step > H_VISIBLE-BOX_SIZE, then box_x becomes H_VISIBLE-BOX_SIZE and the direction flips to left; else box_x += step.
- X axis moving left: if box_x < step, then box_x becomes 0 and the direction flips to right; else box_x -= step.
- Y axis uses the same rules against V_VISIBLE-BOX_SIZE, with down and up directions.
- Both axes update independently in the same cycle. Initial direction after reset is right and down.
- Size edge arithmetic with 12 bits so it cannot overflow.

## Timing

- Single output register stage. blank_n, HS, VS, the colour outputs and frame_start all present the decode of counter state N at cycle N+1, so every output is mutually aligned with one cycle of latency.
- box_x/box_y are registers that change on the cycle after the update cycle.
- box_color and bg_color are sampled every cycle with no holding.
- Reset (asynchronous assert, synchronous deassert release by vga_clk edge) drives:
  - h_cnt=0, v_cnt=0
  - blank_n=0, HS=1, VS=1, colour outputs=0, frame_start=0
  - box_x=BOX_X0, box_y=BOX_Y0, direction right and down
- First clock after reset release: outputs reflect counter (0,0), so frame_start=1 and blank_n=1.
- Reset mid-frame aborts the frame immediately and restarts from the reset state above. No partial update is applied.

## Test plan

- Reset: hold reset_n=0 and check blank_n=0, HS=VS=1, RGB=0, box_x=100, box_y=100. After release, frame_start pulses on the first edge.
- Line/frame timing with defaults:
  - HS period 800 cycles, low for 96, first falling edge 656 cycles after frame_start.
  - VS low for 1600 cycles.
  - frame_start period 420000 cycles.
  - blank_n high for exactly 640 cycles per active line.
- Box edges with enable=0, box_color=FF0000, bg_color=0000FF: pixel (100,100) is FF0000, (199,199) is FF0000, (200,100) is 0000FF, (99,150) is 0000FF.
- Bounce with enable=1, step=15:
  - box_x reads 535 after update 29, then 540 with a flip at update 30, then 525 at update 31.
  - box_y reads 370 at update 18, then 380 with a flip at update 19, then 365.
- Freeze and zero step: with enable toggled to 0, or step=0, across 3 frames, position and direction are unchanged. Re-enabling continues in the stored direction.
- Reset mid-frame: assert reset_n low at line 300 while box_x=250. Check immediate reset values, box_x back to 100, and the next frame_start exactly 1 cycle after release.

Source files
------------

// File: rtl/vga_bounce_controller.sv
// -----------------------------------------------------------------------------
// vga_bounce_controller
//
// Self-contained VGA pixel source. It generates parametrised sync timing and
// draws one solid box that bounces around the visible area. The box moves once
// per frame by a programmable step on each axis and reflects off the screen
// edges. It drives the DE1-SoC VGA DAC pins directly.
//
// Ports:
//   vga_clk      in   pixel clock (the only clock)
//   reset_n      in   asynchronous active-low reset
//   enable       in   animation enable, sampled at the position update
//   step         in   pixels moved per frame on each axis, sampled at update
//   box_color    in   {red, green, blue} of the box, red in the MSBs
//   bg_color     in   background colour, same packing
//   blank_n      out  high during active video
//   HS / VS      out  horizontal / vertical sync, active-low
//   red/green/blue out pixel colour, 0 while blanked
//   frame_start  out  one-cycle pulse on the output cycle of pixel (0,0)
//   box_x/box_y  out  current box top-left position
//
// All pixel outputs come from one register stage and show the decode of the
// counter state from the previous cycle, so they stay mutually aligned.
// -----------------------------------------------------------------------------
module vga_bounce_controller #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter int BOX_SIZE  = 100,
    parameter int BOX_X0    = 100,
    parameter int BOX_Y0    = 100,
    parameter int COLOR_W   = 8
) (
    input  logic                   vga_clk,
    input  logic                   reset_n,
    input  logic                   enable,
    input  logic [3:0]             step,
    input  logic [3*COLOR_W-1:0]   box_color,
    input  logic [3*COLOR_W-1:0]   bg_color,
    output logic                   blank_n,
    output logic                   HS,
    output logic                   VS,
    output logic [COLOR_W-1:0]     red,
    output logic [COLOR_W-1:0]     green,
    output logic [COLOR_W-1:0]     blue,
    output logic                   frame_start,
    output logic [10:0]            box_x,
    output logic [10:0]            box_y
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
    localparam logic [10:0] V_UPDATE = 11'(V_VISIBLE);
    localparam logic [10:0] X_LIMIT  = 11'(H_VISIBLE - BOX_SIZE);
    localparam logic [10:0] Y_LIMIT  = 11'(V_VISIBLE - BOX_SIZE);
    localparam logic [10:0] X_RESET  = 11'(BOX_X0);
    localparam logic [10:0] Y_RESET  = 11'(BOX_Y0);

    // Edge constants are 12 bits so box_x + BOX_SIZE can never wrap.
    localparam logic [11:0] H_VIS12  = 12'(H_VISIBLE);
    localparam logic [11:0] V_VIS12  = 12'(V_VISIBLE);
    localparam logic [11:0] HS_START = 12'(H_VISIBLE + H_FRONT);
    localparam logic [11:0] HS_END   = 12'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [11:0] VS_START = 12'(V_VISIBLE + V_FRONT);
    localparam logic [11:0] VS_END   = 12'(V_VISIBLE + V_FRONT + V_SYNC);
    localparam logic [11:0] BOX_W12  = 12'(BOX_SIZE);

    // One axis of the bounce. fwd=1 means right/down. Returns {new_fwd, new_pos}.
    // Overshooting clamps to the edge and reverses direction.
    function automatic logic [11:0] axis_next(
        input logic [10:0] pos,
        input logic        fwd,
        input logic [10:0] st,
        input logic [10:0] lim
    );
        logic [11:0] sum;
        logic [11:0] res;
        sum = {1'b0, pos} + {1'b0, st};
        if (fwd) begin
            if (sum > {1'b0, lim}) begin
                res = {1'b0, lim};
            end else begin
                res = {1'b1, sum[10:0]};
            end
        end else begin
            if (pos < st) begin
                res = {1'b1, 11'd0};
            end else begin
                res = {1'b0, pos - st};
            end
        end
        return res;
    endfunction

    logic [10:0]          h_cnt_r;
    logic [10:0]          v_cnt_r;
    logic [10:0]          box_x_r;
    logic [10:0]          box_y_r;
    logic                 dir_right_r;
    logic                 dir_down_r;

    logic                 blank_n_r;
    logic                 hs_r;
    logic                 vs_r;
    logic [3*COLOR_W-1:0] rgb_r;
    logic                 frame_start_r;

    logic [11:0]          h_ext_s;
    logic [11:0]          v_ext_s;
    logic                 visible_s;
    logic                 hs_active_s;
    logic                 vs_active_s;
    logic                 hit_s;
    logic [3*COLOR_W-1:0] pix_color_s;
    logic                 update_s;
    logic                 move_s;
    logic [10:0]          step_ext_s;
    logic [11:0]          x_next_s;
    logic [11:0]          y_next_s;

    // Pixel decode of the current counter state.
    always_comb begin
        h_ext_s     = {1'b0, h_cnt_r};
        v_ext_s     = {1'b0, v_cnt_r};
        visible_s   = (h_ext_s < H_VIS12) && (v_ext_s < V_VIS12);
        hs_active_s = (h_ext_s >= HS_START) && (h_ext_s < HS_END);
        vs_active_s = (v_ext_s >= VS_START) && (v_ext_s < VS_END);
        hit_s       = (h_ext_s >= {1'b0, box_x_r}) && (h_ext_s < ({1'b0, box_x_r} + BOX_W12)) &&
                      (v_ext_s >= {1'b0, box_y_r}) && (v_ext_s < ({1'b0, box_y_r} + BOX_W12));
        pix_color_s = '0;
        if (!visible_s) begin
            pix_color_s = '0;
        end else if (hit_s) begin
            pix_color_s = box_color;
        end else begin
            pix_color_s = bg_color;
        end
    end

    // Position update decision: first cycle of the first blanking line.
    always_comb begin
        update_s   = (h_cnt_r == 11'd0) && (v_cnt_r == V_UPDATE);
        move_s     = update_s && enable && (step != 4'd0);
        step_ext_s = {7'd0, step};
        x_next_s   = axis_next(box_x_r, dir_right_r, step_ext_s, X_LIMIT);
        y_next_s   = axis_next(box_y_r, dir_down_r,  step_ext_s, Y_LIMIT);
    end

    // Horizontal and vertical raster counters.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            h_cnt_r <= 11'd0;
            v_cnt_r <= 11'd0;
        end else if (h_cnt_r == H_LAST) begin
            h_cnt_r <= 11'd0;
            if (v_cnt_r == V_LAST) begin
                v_cnt_r <= 11'd0;
            end else begin
                v_cnt_r <= v_cnt_r + 11'd1;
            end
        end else begin
            h_cnt_r <= h_cnt_r + 11'd1;
        end
    end

    // Box position and direction, changed only by the once-per-frame update.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            box_x_r     <= X_RESET;
            box_y_r     <= Y_RESET;
            dir_right_r <= 1'b1;
            dir_down_r  <= 1'b1;
        end else if (move_s) begin
            box_x_r     <= x_next_s[10:0];
            dir_right_r <= x_next_s[11];
            box_y_r     <= y_next_s[10:0];
            dir_down_r  <= y_next_s[11];
        end else begin
            box_x_r     <= box_x_r;
            box_y_r     <= box_y_r;
            dir_right_r <= dir_right_r;
            dir_down_r  <= dir_down_r;
        end
    end

    // Output register stage: one cycle of latency for every pixel output.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            blank_n_r     <= 1'b0;
            hs_r          <= 1'b1;
            vs_r          <= 1'b1;
            rgb_r         <= '0;
            frame_start_r <= 1'b0;
        end else begin
            blank_n_r     <= visible_s;
            hs_r          <= ~hs_active_s;
            vs_r          <= ~vs_active_s;
            rgb_r         <= pix_color_s;
            frame_start_r <= (h_cnt_r == 11'd0) && (v_cnt_r == 11'd0);
        end
    end

    assign blank_n     = blank_n_r;
    assign HS          = hs_r;
    assign VS          = vs_r;
    assign red         = rgb_r[3*COLOR_W-1:2*COLOR_W];
    assign green       = rgb_r[2*COLOR_W-1:COLOR_W];
    assign blue        = rgb_r[COLOR_W-1:0];
    assign frame_start = frame_start_r;
    assign box_x       = box_x_r;
    assign box_y       = box_y_r;

endmodule

// File: tb/tb_vga_bounce_controller.sv
// -----------------------------------------------------------------------------
// Testbench for vga_bounce_controller, using a reduced raster so many frames
// fit in a short run. A pixel-index model predicts every output each cycle;
// literal checks pin reset values, pixel edges and the bounce sequence.
// -----------------------------------------------------------------------------
module tb_vga_bounce_controller;

    localparam int HV = 32, HF = 2, HSW = 4, HB = 2;
    localparam int VV = 24, VF = 1, VSW = 2, VB = 2;
    localparam int BS = 8, X0 = 5, Y0 = 7, CW = 8;
    localparam int HT = HV + HF + HSW + HB;   // 40
    localparam int VT = VV + VF + VSW + VB;   // 29
    localparam int FR = HT * VT;              // 1160

    logic          vga_clk   = 1'b0;
    logic          reset_n   = 1'b1;
    logic          enable    = 1'b0;
    logic [3:0]    step      = 4'd0;
    logic [23:0]   box_color;
    logic [23:0]   bg_color;
    logic          blank_n, HS, VS, frame_start;
    logic [7:0]    red, green, blue;
    logic [10:0]   box_x, box_y;

    int  checks   = 0;
    int  failures = 0;
    bit  cmp_en   = 1'b0;
    bit  rand_col = 1'b0;
    int  edge_n   = 0;

    vga_bounce_controller #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HSW), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VSW), .V_BACK(VB),
        .BOX_SIZE(BS), .BOX_X0(X0), .BOX_Y0(Y0), .COLOR_W(CW)
    ) dut (
        .vga_clk(vga_clk), .reset_n(reset_n), .enable(enable), .step(step),
        .box_color(box_color), .bg_color(bg_color),
        .blank_n(blank_n), .HS(HS), .VS(VS),
        .red(red), .green(green), .blue(blue),
        .frame_start(frame_start), .box_x(box_x), .box_y(box_y)
    );

    always #5 vga_clk = ~vga_clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures <= 20)
                $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Colour inputs change on the falling edge, fixed or random.
    always @(negedge vga_clk) begin
        if (rand_col) begin
            box_color = 24'($urandom);
            bg_color  = 24'($urandom);
        end else begin
            box_color = 24'hFF0000;
            bg_color  = 24'h0000FF;
        end
    end

    // ---------------- behavioural model (pixel index p = v*HT + h) ----------
    int          mdl_p;
    int          mx, my;
    bit          mdr, mdd;
    logic [27:0] exp_out;   // {blank_n, HS, VS, rgb, frame_start}

    function automatic int next_pos(input int pos, input bit fwd, input int st, input int lim);
        if (fwd) return (pos + st > lim) ? lim : pos + st;
        else     return (pos < st) ? 0 : pos - st;
    endfunction

    function automatic bit next_dir(input int pos, input bit fwd, input int st, input int lim);
        if (fwd) return !(pos + st > lim);
        else     return (pos < st);
    endfunction

    function automatic logic [27:0] decode(input int p, input int bx, input int by,
                                           input logic [23:0] bc, input logic [23:0] gc);
        int h, v;
        bit vis, hit, hs, vs;
        logic [23:0] c;
        h   = p % HT;
        v   = p / HT;
        vis = (h < HV) && (v < VV);
        hit = (h >= bx) && (h < bx + BS) && (v >= by) && (v < by + BS);
        hs  = !((h >= HV + HF) && (h < HV + HF + HSW));
        vs  = !((v >= VV + VF) && (v < VV + VF + VSW));
        c   = !vis ? 24'h0 : (hit ? bc : gc);
        return {vis, hs, vs, c, (p == 0)};
    endfunction

    always @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            mdl_p   <= 0;
            exp_out <= {1'b0, 1'b1, 1'b1, 24'h0, 1'b0};
            mx      <= X0;
            my      <= Y0;
            mdr     <= 1'b1;
            mdd     <= 1'b1;
        end else begin
            exp_out <= decode(mdl_p, mx, my, box_color, bg_color);
            mdl_p   <= (mdl_p + 1) % FR;
            if (mdl_p == VV * HT && enable && step != 4'd0) begin
                mx  <= next_pos(mx, mdr, int'(step), HV - BS);
                mdr <= next_dir(mx, mdr, int'(step), HV - BS);
                my  <= next_pos(my, mdd, int'(step), VV - BS);
                mdd <= next_dir(my, mdd, int'(step), VV - BS);
            end
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge vga_clk) begin
        if (cmp_en)
            chk("cycle", {blank_n, HS, VS, red, green, blue, frame_start, box_x, box_y},
                {exp_out, 11'(mx), 11'(my)});
    end

    // Advance to the given output edge after reset release, sample 1 time unit later.
    task automatic to_edge(input int n);
        while (edge_n < n) begin
            @(posedge vga_clk);
            edge_n++;
        end
        #1;
    endtask

    task automatic chk_pos(input string name, input int ex, input int ey);
        chk({name, "_x"}, 64'(box_x), 64'(ex));
        chk({name, "_y"}, 64'(box_y), 64'(ey));
    endtask

    initial begin
        #1 reset_n = 1'b0;
        cmp_en = 1'b1;
        repeat (3) @(negedge vga_clk);
        #1;
        chk("rst_outputs", {blank_n, HS, VS, red, green, blue, frame_start},
            {1'b0, 1'b1, 1'b1, 24'h0, 1'b0});
        chk_pos("rst_pos", X0, Y0);

        // Release; frame 1 with the box frozen and fixed colours.
        reset_n = 1'b1;
        edge_n  = 0;
        to_edge(1);
        chk("first_frame_start", 64'(frame_start), 64'd1);
        chk("first_blank_n", 64'(blank_n), 64'd1);
        to_edge(2);
        chk("frame_start_pulse", 64'(frame_start), 64'd0);
        to_edge(32);  chk("blank_last_vis", 64'(blank_n), 64'd1);
        to_edge(33);  chk("blank_first_blank", 64'(blank_n), 64'd0);
        to_edge(34);  chk("hs_before", 64'(HS), 64'd1);
        to_edge(35);  chk("hs_fall", 64'(HS), 64'd0);
        to_edge(7 * HT + 5 + 1);   chk("pix_5_7",   64'({red, green, blue}), 64'hFF0000);
        to_edge(7 * HT + 13 + 1);  chk("pix_13_7",  64'({red, green, blue}), 64'h0000FF);
        to_edge(10 * HT + 4 + 1);  chk("pix_4_10",  64'({red, green, blue}), 64'h0000FF);
        to_edge(14 * HT + 12 + 1); chk("pix_12_14", 64'({red, green, blue}), 64'hFF0000);
        to_edge(24 * HT + 39 + 1); chk("vs_before", 64'(VS), 64'd1);
        to_edge(25 * HT + 0 + 1);  chk("vs_fall", 64'(VS), 64'd0);
        to_edge(FR);               chk_pos("frozen_f1", X0, Y0);
        to_edge(FR + 1);           chk("frame_start_period", 64'(frame_start), 64'd1);

        // Bounce with step 7: x clamps at 24, y clamps at 16 then at 0.
        rand_col = 1'b1;
        enable   = 1'b1;
        step     = 4'd7;
        to_edge(2 * FR); chk_pos("bounce1", 12, 14);
        to_edge(3 * FR); chk_pos("bounce2", 19, 16);
        to_edge(4 * FR); chk_pos("bounce3", 24, 9);
        to_edge(5 * FR); chk_pos("bounce4", 17, 2);
        to_edge(6 * FR); chk_pos("bounce5", 10, 0);

        // Freeze by enable, then by zero step; direction must be kept.
        enable = 1'b0;
        to_edge(9 * FR);  chk_pos("freeze_en", 10, 0);
        enable = 1'b1;
        step   = 4'd0;
        to_edge(12 * FR); chk_pos("freeze_step", 10, 0);
        step   = 4'd7;
        to_edge(13 * FR); chk_pos("resume", 3, 7);

        // Random enable/step per frame, random colours every cycle.
        for (int f = 14; f < 22; f++) begin
            enable = ($urandom_range(0, 3) != 0);
            step   = 4'($urandom_range(0, 15));
            to_edge(f * FR);
        end

        // Reset in the middle of a visible line.
        enable = 1'b1;
        step   = 4'd5;
        to_edge(22 * FR + 20 * HT + 7);
        @(negedge vga_clk);
        #1 reset_n = 1'b0;
        #1;
        chk("midrst_outputs", {blank_n, HS, VS, red, green, blue, frame_start},
            {1'b0, 1'b1, 1'b1, 24'h0, 1'b0});
        chk_pos("midrst_pos", X0, Y0);
        repeat (2) @(negedge vga_clk);
        #1 reset_n = 1'b1;
        edge_n = 0;
        to_edge(1);
        chk("midrst_frame_start", 64'(frame_start), 64'd1);
        to_edge(FR + 2);

        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
